adder_output_stage: RTL

ADDER_OUTPUT_STAGE -- requirements
Module: adder_output_stage

---
 rtl/adder_output_stage_pkg.sv | 18 +
 rtl/adder_output_stage_skid.sv | 73 +++++++
 rtl/adder_output_stage.sv | 78 +++++++
 3 files changed

// File: rtl/adder_output_stage_pkg.sv
// Shared definitions for the adder output stage: flag bit positions, skid state
// encoding and overflow counter width.
package adder_output_stage_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/adder_output_stage_skid.sv
// result_skid_buffer: 2-entry skid buffer, output register plus one skid slot.
// Both handshake outputs decode straight from the state flop.
import adder_output_stage_pkg::*;

module result_skid_buffer #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, xfer;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = out_q;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          out_d   = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && xfer) begin
          out_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // Oldest entry leaves; the skid slot becomes the head.
        if (xfer) begin
          out_d   = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/adder_output_stage.sv
// Registers adder results with NZCV flags behind a skid buffer and counts
// overflowed beats. Define ADDER_SATURATE_EN to clamp overflowed sums.
import adder_output_stage_pkg::*;

module adder_output_stage #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  input  logic             in_cout,
  input  logic             in_of,
  input  logic             in_a_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [3:0]       out_flags,
  input  logic             clr_count,
  output logic [CNT_W-1:0] of_count
);

  logic [N-1:0]     sum_st;
  logic [3:0]       flags;
  logic [N+3:0]     out_pl;
  logic [CNT_W-1:0] of_count_q, of_count_d;

`ifdef ADDER_SATURATE_EN
  // Overflow direction follows A's sign: negative A clamps to most-negative.
  always_comb begin
    sum_st = in_sum;
    if (in_of) sum_st = in_a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  logic unused_a_msb;
  assign unused_a_msb = in_a_msb;
  assign sum_st       = in_sum;
`endif

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = sum_st[N-1];
    flags[FLAG_Z] = (sum_st == '0);
    flags[FLAG_C] = in_cout;
    flags[FLAG_V] = in_of;
  end

  result_skid_buffer #(.W(N+4)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({flags, sum_st}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_sum   = out_pl[N-1:0];
  assign out_flags = out_pl[N+3:N];

  always_comb begin
    of_count_d = of_count_q;
    if (clr_count)
      of_count_d = '0;
    else if (in_valid && in_ready && in_of && (of_count_q != '1))
      of_count_d = of_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) of_count_q <= '0;
    else        of_count_q <= of_count_d;
  end

  assign of_count = of_count_q;

endmodule
